// File: rtl/tlb_ctrl_pkg.sv
// Shared constants for the CP0 TLB instruction sequencer: op codes, FSM encoding,
// CP0 register field positions and the EntryLo packing helper.
package tlb_ctrl_pkg;

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWI = 2'b10;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PROBE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int HI_VPN2_MSB = 31;
  localparam int HI_VPN2_LSB = 13;
  localparam int HI_ASID_MSB = 7;
  localparam int HI_ASID_LSB = 0;

  localparam int LO_PFN_MSB = 25;
  localparam int LO_PFN_LSB = 6;
  localparam int LO_C_MSB   = 5;
  localparam int LO_C_LSB   = 3;
  localparam int LO_D       = 2;
  localparam int LO_V       = 1;
  localparam int LO_G       = 0;

  localparam int IDX_P = 31;

  localparam logic [31:0] INDEX_P_BIT = 32'h8000_0000;

  function automatic logic [31:0] pack_entrylo(input logic [19:0] pfn, input logic [2:0] c,
                                               input logic d, input logic v, input logic g);
    return {6'b0, pfn, c, d, v, g};
  endfunction

endpackage

// File: rtl/tlb_random_cnt.sv
// CP0 Random register: free-running down-counter over the TLB index range,
// wrapping from 0 back to TLBNUM-1 (TLBNUM is a power of two).
module tlb_random_cnt
  import tlb_ctrl_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  output logic [IDXW-1:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) value <= IDXW'(TLBNUM - 1);
    else       value <= value - 1'b1;
  end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for CP0 TLBP/TLBR/TLBWI/TLBWR between WB and the TLB.
// Optional feature macro TLB_RANDOM_EN: Random counter present, TLBWR uses the latched random index.
module tlb_op_ctrl
  import tlb_ctrl_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [1:0]      op_code,
  input  logic [31:0]     c0_entryhi,
  input  logic [31:0]     c0_entrylo0,
  input  logic [31:0]     c0_entrylo1,
  input  logic [31:0]     c0_index,
  output logic            op_done,
  output logic            c0_index_we,
  output logic            c0_entryhi_we,
  output logic            c0_entrylo0_we,
  output logic            c0_entrylo1_we,
  output logic [31:0]     c0_index_wdata,
  output logic [31:0]     c0_entryhi_wdata,
  output logic [31:0]     c0_entrylo0_wdata,
  output logic [31:0]     c0_entrylo1_wdata,
  output logic            tlb_s1_own,
  output logic [18:0]     s1_vpn2,
  output logic            s1_odd_page,
  output logic [7:0]      s1_asid,
  input  logic            s1_found,
  input  logic [IDXW-1:0] s1_index,
  output logic [IDXW-1:0] r_index,
  input  logic [18:0]     r_vpn2,
  input  logic [7:0]      r_asid,
  input  logic            r_g,
  input  logic [19:0]     r_pfn0,
  input  logic [2:0]      r_c0,
  input  logic            r_d0,
  input  logic            r_v0,
  input  logic [19:0]     r_pfn1,
  input  logic [2:0]      r_c1,
  input  logic            r_d1,
  input  logic            r_v1,
  output logic            we,
  output logic [IDXW-1:0] w_index,
  output logic [18:0]     w_vpn2,
  output logic [7:0]      w_asid,
  output logic            w_g,
  output logic [19:0]     w_pfn0,
  output logic [2:0]      w_c0,
  output logic            w_d0,
  output logic            w_v0,
  output logic [19:0]     w_pfn1,
  output logic [2:0]      w_c1,
  output logic            w_d1,
  output logic            w_v1,
  output logic            tlb_refetch,
  output logic [IDXW-1:0] random_value
);

  logic [2:0]      state, state_nxt;
  logic            accept;

  logic [1:0]      snap_op;
  logic [18:0]     snap_vpn2;
  logic [7:0]      snap_asid;
  logic [IDXW-1:0] snap_idx;
  logic [25:0]     snap_lo0, snap_lo1;

  logic            pr_found;
  logic [IDXW-1:0] pr_index;
  logic [18:0]     rd_vpn2;
  logic [7:0]      rd_asid;
  logic            rd_g;
  logic [19:0]     rd_pfn0, rd_pfn1;
  logic [2:0]      rd_c0, rd_c1;
  logic            rd_d0, rd_d1, rd_v0, rd_v1;

  logic            st_done;
  logic            unused_bits;

  assign accept = op_valid && (state == ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (op_valid) begin
          case (op_code)
            OP_TLBP: state_nxt = ST_PROBE;
            OP_TLBR: state_nxt = ST_READ;
            default: state_nxt = ST_WRITE;
          endcase
        end
      end
      ST_PROBE, ST_READ, ST_WRITE: state_nxt = ST_DONE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  // Only the fields actually consumed are snapshotted; the rest of each CP0 word is don't-care.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_op   <= '0;
      snap_vpn2 <= '0;
      snap_asid <= '0;
      snap_idx  <= '0;
      snap_lo0  <= '0;
      snap_lo1  <= '0;
    end else if (accept) begin
      snap_op   <= op_code;
      snap_vpn2 <= c0_entryhi[HI_VPN2_MSB:HI_VPN2_LSB];
      snap_asid <= c0_entryhi[HI_ASID_MSB:HI_ASID_LSB];
      snap_idx  <= c0_index[IDXW-1:0];
      snap_lo0  <= c0_entrylo0[LO_PFN_MSB:0];
      snap_lo1  <= c0_entrylo1[LO_PFN_MSB:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pr_found <= 1'b0;
      pr_index <= '0;
    end else if (state == ST_PROBE) begin
      pr_found <= s1_found;
      pr_index <= s1_index;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vpn2 <= '0;
      rd_asid <= '0;
      rd_g    <= 1'b0;
      rd_pfn0 <= '0;
      rd_c0   <= '0;
      rd_d0   <= 1'b0;
      rd_v0   <= 1'b0;
      rd_pfn1 <= '0;
      rd_c1   <= '0;
      rd_d1   <= 1'b0;
      rd_v1   <= 1'b0;
    end else if (state == ST_READ) begin
      rd_vpn2 <= r_vpn2;
      rd_asid <= r_asid;
      rd_g    <= r_g;
      rd_pfn0 <= r_pfn0;
      rd_c0   <= r_c0;
      rd_d0   <= r_d0;
      rd_v0   <= r_v0;
      rd_pfn1 <= r_pfn1;
      rd_c1   <= r_c1;
      rd_d1   <= r_d1;
      rd_v1   <= r_v1;
    end
  end

`ifdef TLB_RANDOM_EN
  logic [IDXW-1:0] snap_rand;

  tlb_random_cnt #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_random (
    .clk   (clk),
    .reset (reset),
    .value (random_value)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       snap_rand <= '0;
    else if (accept) snap_rand <= random_value;
  end

  assign w_index = (snap_op == OP_TLBWR) ? snap_rand : snap_idx;
`else
  assign random_value = IDXW'(TLBNUM - 1);
  assign w_index      = snap_idx;
`endif

  assign op_ready    = (state == ST_IDLE);
  assign tlb_s1_own  = (state == ST_PROBE);
  assign we          = (state == ST_WRITE);
  assign st_done     = (state == ST_DONE);
  assign op_done     = st_done;

  assign s1_vpn2     = snap_vpn2;
  assign s1_asid     = snap_asid;
  assign s1_odd_page = 1'b0;
  assign r_index     = snap_idx;

  // A global mapping needs G set on both halves of the pair.
  assign w_vpn2 = snap_vpn2;
  assign w_asid = snap_asid;
  assign w_g    = snap_lo0[LO_G] & snap_lo1[LO_G];
  assign w_pfn0 = snap_lo0[LO_PFN_MSB:LO_PFN_LSB];
  assign w_c0   = snap_lo0[LO_C_MSB:LO_C_LSB];
  assign w_d0   = snap_lo0[LO_D];
  assign w_v0   = snap_lo0[LO_V];
  assign w_pfn1 = snap_lo1[LO_PFN_MSB:LO_PFN_LSB];
  assign w_c1   = snap_lo1[LO_C_MSB:LO_C_LSB];
  assign w_d1   = snap_lo1[LO_D];
  assign w_v1   = snap_lo1[LO_V];

  assign c0_index_we    = st_done && (snap_op == OP_TLBP);
  assign c0_entryhi_we  = st_done && (snap_op == OP_TLBR);
  assign c0_entrylo0_we = st_done && (snap_op == OP_TLBR);
  assign c0_entrylo1_we = st_done && (snap_op == OP_TLBR);
  assign tlb_refetch    = st_done && snap_op[1];

  assign c0_index_wdata    = pr_found ? 32'(pr_index) : INDEX_P_BIT;
  assign c0_entryhi_wdata  = {rd_vpn2, 5'b0, rd_asid};
  assign c0_entrylo0_wdata = pack_entrylo(rd_pfn0, rd_c0, rd_d0, rd_v0, rd_g);
  assign c0_entrylo1_wdata = pack_entrylo(rd_pfn1, rd_c1, rd_d1, rd_v1, rd_g);

  assign unused_bits = &{1'b0, c0_entryhi[HI_VPN2_LSB-1:HI_ASID_MSB+1],
                         c0_entrylo0[31:LO_PFN_MSB+1], c0_entrylo1[31:LO_PFN_MSB+1],
                         c0_index[IDX_P:IDXW]};

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Self-checking bench for tlb_op_ctrl: a small TLB array answers the DUT's ports,
// and a CP0-level reference model predicts every op's TLB and CP0 effects.
module tb_tlb_op_ctrl;

  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            op_valid = 1'b0;
  logic            op_ready;
  logic [1:0]      op_code = 2'b00;
  logic [31:0]     c0_entryhi = '0, c0_entrylo0 = '0, c0_entrylo1 = '0, c0_index = '0;
  logic            op_done;
  logic            c0_index_we, c0_entryhi_we, c0_entrylo0_we, c0_entrylo1_we;
  logic [31:0]     c0_index_wdata, c0_entryhi_wdata, c0_entrylo0_wdata, c0_entrylo1_wdata;
  logic            tlb_s1_own;
  logic [18:0]     s1_vpn2;
  logic            s1_odd_page;
  logic [7:0]      s1_asid;
  logic            s1_found;
  logic [IDXW-1:0] s1_index;
  logic [IDXW-1:0] r_index;
  logic [18:0]     r_vpn2;
  logic [7:0]      r_asid;
  logic            r_g;
  logic [19:0]     r_pfn0, r_pfn1;
  logic [2:0]      r_c0, r_c1;
  logic            r_d0, r_d1, r_v0, r_v1;
  logic            we;
  logic [IDXW-1:0] w_index;
  logic [18:0]     w_vpn2;
  logic [7:0]      w_asid;
  logic            w_g;
  logic [19:0]     w_pfn0, w_pfn1;
  logic [2:0]      w_c0, w_c1;
  logic            w_d0, w_d1, w_v0, w_v1;
  logic            tlb_refetch;
  logic [IDXW-1:0] random_value;

  int checks;
  int errors;
  int cyc = 0;
  logic envInit = 1'b1;

  logic [31:0] memHi  [TLBNUM];
  logic [31:0] memLo0 [TLBNUM];
  logic [31:0] memLo1 [TLBNUM];
  logic [31:0] refHi  [TLBNUM];
  logic [31:0] refLo0 [TLBNUM];
  logic [31:0] refLo1 [TLBNUM];

  always #5 clk = ~clk;

  tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .c0_entryhi(c0_entryhi), .c0_entrylo0(c0_entrylo0), .c0_entrylo1(c0_entrylo1),
    .c0_index(c0_index), .op_done(op_done),
    .c0_index_we(c0_index_we), .c0_entryhi_we(c0_entryhi_we),
    .c0_entrylo0_we(c0_entrylo0_we), .c0_entrylo1_we(c0_entrylo1_we),
    .c0_index_wdata(c0_index_wdata), .c0_entryhi_wdata(c0_entryhi_wdata),
    .c0_entrylo0_wdata(c0_entrylo0_wdata), .c0_entrylo1_wdata(c0_entrylo1_wdata),
    .tlb_s1_own(tlb_s1_own), .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .tlb_refetch(tlb_refetch), .random_value(random_value)
  );

  // The TLB itself, stored as CP0-format words; it keeps its contents across reset.
  always @(posedge clk) begin
    if (envInit) begin
      for (int i = 0; i < TLBNUM; i++) begin
        memHi[i]  <= initHi(i);
        memLo0[i] <= initLo(i);
        memLo1[i] <= initLo(i + 100);
      end
    end else if (we) begin
      memHi[w_index]  <= {w_vpn2, 5'b0, w_asid};
      memLo0[w_index] <= {6'b0, w_pfn0, w_c0, w_d0, w_v0, w_g};
      memLo1[w_index] <= {6'b0, w_pfn1, w_c1, w_d1, w_v1, w_g};
    end
  end

  assign r_vpn2 = memHi[r_index][31:13];
  assign r_asid = memHi[r_index][7:0];
  assign r_g    = memLo0[r_index][0];
  assign {r_pfn0, r_c0, r_d0, r_v0} = memLo0[r_index][25:1];
  assign {r_pfn1, r_c1, r_d1, r_v1} = memLo1[r_index][25:1];

  always_comb begin
    s1_found = 1'b0;
    s1_index = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      if (memHi[i][31:13] == s1_vpn2 && (memLo0[i][0] || memHi[i][7:0] == s1_asid)) begin
        s1_found = 1'b1;
        s1_index = s1_index | 4'(i);
      end
    end
  end

  // Cycles elapsed since reset was last released drive the Random prediction.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [31:0] initHi(input int i);
    return {1'b1, 14'h3FFF, 4'(i), 5'b0, 8'hFF};
  endfunction

  function automatic logic [31:0] initLo(input int i);
    return {6'b0, 20'(i + 1), 3'b010, 1'b1, 1'b1, 1'b0};
  endfunction

  function automatic logic [3:0] expRandom();
`ifdef TLB_RANDOM_EN
    return 4'((TLBNUM - 1) - (cyc % TLBNUM));
`else
    return 4'(TLBNUM - 1);
`endif
  endfunction

  function automatic logic [31:0] expProbe(input logic [31:0] hi);
    for (int j = 0; j < TLBNUM; j++)
      if (refHi[j][31:13] == hi[31:13] && (refLo0[j][0] || refHi[j][7:0] == hi[7:0]))
        return 32'(j);
    return 32'h8000_0000;
  endfunction

  task automatic modelWrite(input logic [3:0] t, input logic [31:0] hi, lo0, lo1);
    logic g;
    g = lo0[0] & lo1[0];
    refHi[t]  = hi & 32'hFFFF_E0FF;
    refLo0[t] = {6'b0, lo0[25:1], g};
    refLo1[t] = {6'b0, lo1[25:1], g};
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] hi, lo0, lo1, idx,
                               input bit abortInWrite);
    logic [3:0] tgt;
    checkOutput("idle_ready", {31'b0, op_ready}, 32'd1);
    checkOutput("random_at_accept", {28'b0, random_value}, {28'b0, expRandom()});
    tgt = idx[3:0];
`ifdef TLB_RANDOM_EN
    if (op == 2'b11) tgt = expRandom();
`endif
    op_valid = 1'b1; op_code = op;
    c0_entryhi = hi; c0_entrylo0 = lo0; c0_entrylo1 = lo1; c0_index = idx;
    @(negedge clk);
    op_valid = 1'b0;
    checkOutput("busy", {30'b0, op_ready, op_done}, 32'd0);
    case (op)
      2'b00: begin
        checkOutput("probe_ctl", {29'b0, tlb_s1_own, we, s1_odd_page}, 32'b100);
        checkOutput("probe_key", {5'b0, s1_vpn2, s1_asid}, {5'b0, hi[31:13], hi[7:0]});
      end
      2'b01: checkOutput("read_ctl", {26'b0, tlb_s1_own, we, r_index}, {26'b0, 2'b00, idx[3:0]});
      default: begin
        checkOutput("write_ctl", {26'b0, tlb_s1_own, we, w_index}, {26'b0, 2'b01, tgt});
        checkOutput("write_hi", {4'b0, w_vpn2, w_asid, w_g}, {4'b0, hi[31:13], hi[7:0], lo0[0] & lo1[0]});
        checkOutput("write_lo0", {7'b0, w_pfn0, w_c0, w_d0, w_v0}, {7'b0, lo0[25:1]});
        checkOutput("write_lo1", {7'b0, w_pfn1, w_c1, w_d1, w_v1}, {7'b0, lo1[25:1]});
        if (!abortInWrite) modelWrite(tgt, hi, lo0, lo1);
      end
    endcase
    if (abortInWrite) begin
      reset = 1'b1;
      #1;
      checkOutput("reset_midwrite", {27'b0, we, op_ready, op_done, tlb_refetch, tlb_s1_own}, 32'b01000);
      @(negedge clk);
      reset = 1'b0;
      checkOutput("reset_random", {28'b0, random_value}, {28'b0, expRandom()});
    end else begin
      @(negedge clk);
      case (op)
        2'b00: begin
          checkOutput("probe_done", {24'b0, op_done, c0_index_we, c0_entryhi_we, c0_entrylo0_we,
                      c0_entrylo1_we, tlb_refetch, we, tlb_s1_own}, 32'b1100_0000);
          checkOutput("probe_index", c0_index_wdata, expProbe(hi));
        end
        2'b01: begin
          checkOutput("read_done", {24'b0, op_done, c0_index_we, c0_entryhi_we, c0_entrylo0_we,
                      c0_entrylo1_we, tlb_refetch, we, tlb_s1_own}, 32'b1011_1000);
          checkOutput("read_hi", c0_entryhi_wdata, refHi[idx[3:0]]);
          checkOutput("read_lo0", c0_entrylo0_wdata, refLo0[idx[3:0]]);
          checkOutput("read_lo1", c0_entrylo1_wdata, refLo1[idx[3:0]]);
        end
        default:
          checkOutput("write_done", {24'b0, op_done, c0_index_we, c0_entryhi_we, c0_entrylo0_we,
                      c0_entrylo1_we, tlb_refetch, we, tlb_s1_own}, 32'b1000_0100);
      endcase
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  op;
    logic [3:0]  tgt;
    logic [31:0] hi, idx;
    int j;
    checks = 0;
    errors = 0;
    for (int i = 0; i < TLBNUM; i++) begin
      refHi[i]  = initHi(i);
      refLo0[i] = initLo(i);
      refLo1[i] = initLo(i + 100);
    end

    #2 reset = 1'b1;
    #1;
    checkOutput("reset_ctl", {25'b0, op_ready, op_done, we, tlb_s1_own, tlb_refetch,
                c0_index_we, c0_entryhi_we | c0_entrylo0_we | c0_entrylo1_we}, 32'b100_0000);
    checkOutput("reset_random", {28'b0, random_value}, 32'd15);
    @(negedge clk);
    envInit = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 18; k++) begin
      checkOutput("random_seq", {28'b0, random_value}, {28'b0, expRandom()});
      @(negedge clk);
    end

    applyStimulus(2'b10, 32'h0000_2005, 32'h0000_0047, 32'h0000_0087, 32'd5, 1'b0);
    applyStimulus(2'b00, 32'h0000_2005, 32'h0, 32'h0, 32'h0, 1'b0);
    applyStimulus(2'b10, {1'b1, 14'h0123, 4'd6, 5'b0, 8'h11}, 32'h0000_0046, 32'h0000_0087, 32'd6, 1'b0);
    applyStimulus(2'b00, {1'b1, 14'h0123, 4'd6, 5'b0, 8'h22}, 32'h0, 32'h0, 32'h0, 1'b0);
    applyStimulus(2'b01, 32'h0, 32'h0, 32'h0, 32'd5, 1'b0);

`ifdef TLB_RANDOM_EN
    for (int k = 0; k < 20 && expRandom() != 4'd9; k++) @(negedge clk);
`endif
    applyStimulus(2'b11, {1'b1, 14'h0456, expRandom() == 4'd9 ? 4'd9 : 4'd2, 5'b0, 8'h33},
                  32'h0000_1234, 32'h0000_5679, 32'd2, 1'b0);

    applyStimulus(2'b10, {1'b1, 14'h0777, 4'd5, 5'b0, 8'h44}, 32'h00FF_FFFF, 32'h00FF_FFFF, 32'd5, 1'b1);
    applyStimulus(2'b01, 32'h0, 32'h0, 32'h0, 32'd5, 1'b0);

    op_valid = 1'b1; op_code = 2'b01; c0_index = 32'd5;
    for (int k = 0; k < 9; k++) begin
      checkOutput("stream_ready", {31'b0, op_ready}, {31'b0, k % 3 == 0});
      checkOutput("stream_done", {31'b0, op_done}, {31'b0, k % 3 == 2});
      if (k == 8) op_valid = 1'b0;
      @(negedge clk);
    end

    for (int n = 0; n < 60; n++) begin
      op  = 2'($urandom);
      idx = $urandom;
      tgt = idx[3:0];
`ifdef TLB_RANDOM_EN
      if (op == 2'b11) tgt = expRandom();
`endif
      if (op == 2'b00) begin
        j = $urandom_range(0, TLBNUM - 1);
        if ($urandom_range(0, 3) == 0) hi = $urandom;
        else hi = {refHi[j][31:13], 5'($urandom), $urandom_range(0, 1) ? refHi[j][7:0] : 8'($urandom)};
      end else begin
        hi = {1'b1, 14'($urandom), tgt, 13'($urandom)};
      end
      applyStimulus(op, hi, $urandom, $urandom, idx, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequencer for the CP0 TLB instructions (TLBP, TLBR, TLBWI, TLBWR), sitting between the WB stage and the 16-entry TLB. It snapshots CP0 EntryHi/EntryLo0/EntryLo1/Index and borrows TLB search port 1 for probes. It drives the TLB read and write ports and returns CP0 update strobes. It also maintains the Random index and signals a pipeline refetch after every TLB write.

## Interface
- TLBNUM, 16, TLB entry count (power of two); IDXW = $clog2(TLBNUM)
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- op_valid / op_ready  in / out  1 / 1  request handshake from WB
- op_code  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
- c0_entryhi, c0_entrylo0, c0_entrylo1, c0_index  in  32 each  current CP0 values
- op_done  out  1  one-cycle completion pulse
- c0_index_we, c0_entryhi_we, c0_entrylo0_we, c0_entrylo1_we  out  1 each  CP0 write strobes
- c0_index_wdata, c0_entryhi_wdata, c0_entrylo0_wdata, c0_entrylo1_wdata  out  32 each
- tlb_s1_own  out  1  search port 1 mux select (1 = this block)
- s1_vpn2 / s1_odd_page / s1_asid  out  19/1/8;  s1_found / s1_index  in  1/IDXW
- r_index  out  IDXW;  r_vpn2, r_asid, r_g, r_pfn0/1, r_c0/1, r_d0/1, r_v0/1  in  TLB widths
- we, w_index, w_vpn2, w_asid, w_g, w_pfn0/1, w_c0/1, w_d0/1, w_v0/1  out  TLB widths
- tlb_refetch  out  1  pulse: flush and refetch after a write
- random_value  out  IDXW  current Random register

## Operation
- Field layout: EntryHi VPN2 [31:13], ASID [7:0]. EntryLo PFN [25:6], C [5:3], D [2], V [1], G [0]. Index P [31], index [IDXW-1:0] (upper bits ignored).
- FSM states: IDLE, PROBE, READ, WRITE, DONE. op_ready = (state == IDLE).
- Accept in IDLE on op_valid. The block latches op_code, all four CP0 inputs and random_value, then moves to PROBE, READ or WRITE (TLBWI and TLBWR both go to WRITE).
- PROBE:
  - tlb_s1_own = 1; s1_vpn2/s1_asid come from the snapshot EntryHi; s1_odd_page = 0.
  - s1_found and s1_index are registered at the cycle end; next state DONE.
- READ: r_index = snapshot index; all r_* fields are registered; next state DONE.
- WRITE:
  - we = 1 for exactly one cycle; next state DONE.
  - w_index = snapshot index for TLBWI, latched random for TLBWR.
  - w_vpn2/w_asid come from EntryHi; pfn/c/d/v come from the corresponding EntryLo.
  - w_g = G0 & G1.
- DONE: op_done = 1; next state IDLE. Strobes depend on the op:
  - TLBP: c0_index_we; wdata = {1'b0, zero-ext index} if found, else 32'h8000_0000.
  - TLBR:
    - entryhi/entrylo0/entrylo1 _we asserted.
    - EntryHi = {vpn2, 5'b0, asid}.
    - EntryLo0 = {6'b0, pfn0, c0, d0, v0, g}; EntryLo1 is built the same way from the odd-page fields.
  - TLBWI/TLBWR: tlb_refetch = 1.
- All strobes, we and tlb_s1_own are 0 outside their state. A write to the TLB is never partial.
- Once accepted, an operation always completes; no cancel input exists.
- Multiple probe hits: the OR-combined s1_index is used as-is; software guarantees uniqueness.

## Timing
- Accept cycle N; PROBE/READ/WRITE at N+1; op_done and strobes at N+2; next accept no earlier than N+3.
- Reset (asynchronous, any state):
  - state goes to IDLE; all strobes, we, op_done, tlb_refetch and tlb_s1_own go to 0 immediately.
  - random_value = TLBNUM-1; latched registers go to 0.
  - An in-flight op is dropped, with no TLB or CP0 side effect.
- Random: decrements by 1 every cycle not in reset. It wraps from 0 to TLBNUM-1 and is unaffected by ops.

## Configuration
- TLB_RANDOM_EN defined: the Random counter exists and TLBWR writes at the latched random index.
- TLB_RANDOM_EN undefined: no counter; random_value is tied to TLBNUM-1; TLBWR behaves exactly as TLBWI.

## Structure
- Package tlb_ctrl_pkg holds:
  - op code constants, FSM state encoding;
  - EntryHi/EntryLo/Index field bit positions;
  - the P-bit constant 32'h8000_0000.
- One sub-module, tlb_random_cnt: the Random down-counter, instantiated only under TLB_RANDOM_EN.

## Test plan
- TLBWI with Index=5, EntryHi=0x0000_2005, Lo0=0x0000_0047, Lo1=0x0000_0087 -> at N+1: we=1, w_index=5, w_vpn2=1, w_asid=5, w_g=1, pfn0=1, pfn1=2; at N+2: tlb_refetch=1, op_done=1.
- TLBP after the above with matching EntryHi -> at N+1: tlb_s1_own=1; at N+2: c0_index_wdata=0x0000_0005. With a non-matching ASID and G clear in entry 6 -> wdata=0x8000_0000.
- TLBR Index=5 -> EntryHi wdata=0x0000_2005, EntryLo0 wdata=0x0000_0047, EntryLo1 wdata=0x0000_0087 (G replicated).
- Random: count from reset release 0,1,2… cycles -> random_value 15,14,…,0,15. TLBWR accepted when random_value=9 -> w_index=9. With the macro undefined, TLBWR uses Index.
- Reset asserted during the WRITE cycle -> we drops the same cycle, entry unchanged (read back); op_ready=1 after release.
- op_valid held high continuously -> accepts every 3 cycles; op_ready=0 in PROBE/READ/WRITE/DONE.
